// File: rtl/regfile_ctx_seq_if.sv
// Handshake and register-file bundle for the context sequencer.
// master = sequencer side, slave = register file / stream / command environment.
interface regfile_ctx_seq_if #(
    parameter int log2regs = 3,
    parameter int size     = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_save;
    logic                busy;
    logic                done;

    logic                rf_WE0;
    logic                rf_WE1;
    logic [log2regs-1:0] rf_address_in0;
    logic [log2regs-1:0] rf_address_in1;
    logic [size-1:0]     rf_in0;
    logic [size-1:0]     rf_in1;
    logic [log2regs-1:0] rf_address_out0;
    logic [size-1:0]     rf_out0;

    logic                s_valid;
    logic                s_ready;
    logic [size-1:0]     s_data;

    logic                m_valid;
    logic                m_ready;
    logic [size-1:0]     m_data;
    logic                m_last;

    modport master (
        input  cmd_valid, cmd_save, rf_out0, s_valid, s_data, m_ready,
        output cmd_ready, busy, done,
        output rf_WE0, rf_WE1, rf_address_in0, rf_address_in1, rf_in0, rf_in1, rf_address_out0,
        output s_ready, m_valid, m_data, m_last
    );

    modport slave (
        output cmd_valid, cmd_save, rf_out0, s_valid, s_data, m_ready,
        input  cmd_ready, busy, done,
        input  rf_WE0, rf_WE1, rf_address_in0, rf_address_in1, rf_in0, rf_in1, rf_address_out0,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/regfile_ctx_seq.sv
// Context save/restore sequencer: save streams every register out through a 2-entry FIFO, restore writes beats back in pairs one cycle after each odd beat.
// Save reads stall on FIFO room and m_ready; restore holds s_ready until the last beat. Macro REGFILE_CTX_CHECKSUM_EN adds an XOR checksum beat and ck_err.
module regfile_ctx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         CGRA_Clock,
    input  logic                         CGRA_Reset,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop_rdy,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign push_ok  = push_vld && (cnt != CNTW'(DEPTH));
    assign pop_ok   = pop_rdy && (cnt != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
        if (!CGRA_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module regfile_ctx_seq #(
    parameter int log2regs = 3,
    parameter int size     = 32
) (
    input  logic CGRA_Clock,
    input  logic CGRA_Reset,
    regfile_ctx_seq_if.master bus
`ifdef REGFILE_CTX_CHECKSUM_EN
    ,
    output logic ck_err
`endif
);
    localparam int NREGS = 1 << log2regs;
`ifdef REGFILE_CTX_CHECKSUM_EN
    localparam int NBEATS = NREGS + 1;
`else
    localparam int NBEATS = NREGS;
`endif
    localparam int CW = log2regs + 1;
    localparam logic [CW-1:0]       N_REGS_C  = CW'(NREGS);
    localparam logic [CW-1:0]       N_BEATS_C = CW'(NBEATS);
    localparam logic [CW-1:0]       LAST_BEAT = CW'(NBEATS - 1);
    localparam logic [log2regs-1:0] ONE_A     = log2regs'(1);

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;
    state_t state_q, state_d;

    logic                cmd_acc;
    logic                rd_room, rd_issue, rd_is_ck, rd_real;
    logic                rd_pend_q, pend_ck_q;
    logic [CW-1:0]       rd_idx_q, tx_cnt_q, rx_cnt_q;
    logic [log2regs-1:0] raddr_q;
    logic [1:0]          fifo_cnt;
    logic                fifo_empty;
    logic [size-1:0]     fifo_head, push_dat;
    logic                m_xfer, s_acc, rx_data, restore_end;
    logic [size-1:0]     ck_acc_q, pend_q;
    logic                wr_vld_q;
    logic [log2regs-1:0] waddr0_q, waddr1_q;
    logic [size-1:0]     wdat0_q, wdat1_q;

    // Index NREGS is the checksum slot: it takes a throttle slot like a read but drives no address.
    assign cmd_acc  = (state_q == IDLE) && bus.cmd_valid;
    assign rd_room  = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && !rd_pend_q);
    assign rd_issue = (state_q == SAVE) && (rd_idx_q < N_BEATS_C) && rd_room;
    assign rd_is_ck = (rd_idx_q == N_REGS_C);
    assign rd_real  = rd_issue && !rd_is_ck;
    assign bus.rf_address_out0 = rd_real ? rd_idx_q[log2regs-1:0] : raddr_q;

    assign push_dat   = pend_ck_q ? ck_acc_q : bus.rf_out0;
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign bus.m_valid = !fifo_empty;
    assign bus.m_data  = fifo_head;
    assign bus.m_last  = !fifo_empty && (tx_cnt_q == LAST_BEAT);
    assign m_xfer      = bus.m_valid && bus.m_ready;

    assign bus.s_ready = (state_q == RESTORE) && (rx_cnt_q < N_BEATS_C);
    assign s_acc       = bus.s_ready && bus.s_valid;
    assign rx_data     = s_acc && (rx_cnt_q < N_REGS_C);

    assign bus.rf_WE0         = wr_vld_q;
    assign bus.rf_WE1         = wr_vld_q;
    assign bus.rf_address_in0 = waddr0_q;
    assign bus.rf_address_in1 = waddr1_q;
    assign bus.rf_in0         = wdat0_q;
    assign bus.rf_in1         = wdat1_q;

`ifdef REGFILE_CTX_CHECKSUM_EN
    assign restore_end = s_acc && (rx_cnt_q == N_REGS_C);
`else
    assign restore_end = wr_vld_q && (rx_cnt_q == N_REGS_C);
`endif

    regfile_ctx_fifo #(.WIDTH(size), .DEPTH(2)) u_out_fifo (
        .CGRA_Clock (CGRA_Clock),
        .CGRA_Reset (CGRA_Reset),
        .push_vld   (rd_pend_q),
        .push_dat   (push_dat),
        .pop_rdy    (m_xfer),
        .head_dat   (fifo_head),
        .cnt        (fifo_cnt)
    );

    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
        if (!CGRA_Reset) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) state_d = bus.cmd_save ? SAVE : RESTORE;
            end
            SAVE:    if (m_xfer && bus.m_last) state_d = DONE;
            RESTORE: if (restore_end) state_d = DONE;
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
        if (!CGRA_Reset) begin
            rd_idx_q  <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
            pend_ck_q <= 1'b0;
            raddr_q   <= '0;
            ck_acc_q  <= '0;
            pend_q    <= '0;
            wr_vld_q  <= 1'b0;
            waddr0_q  <= '0;
            waddr1_q  <= '0;
            wdat0_q   <= '0;
            wdat1_q   <= '0;
        end else begin
            rd_pend_q <= rd_issue;
            pend_ck_q <= rd_issue && rd_is_ck;
            wr_vld_q  <= 1'b0;
            if (cmd_acc) begin
                rd_idx_q <= '0;
                tx_cnt_q <= '0;
                rx_cnt_q <= '0;
                ck_acc_q <= '0;
            end else begin
                if (rd_issue) rd_idx_q <= rd_idx_q + 1'b1;
                if (m_xfer)   tx_cnt_q <= tx_cnt_q + 1'b1;
                if (s_acc)    rx_cnt_q <= rx_cnt_q + 1'b1;
                if (rd_pend_q && !pend_ck_q) ck_acc_q <= ck_acc_q ^ bus.rf_out0;
                else if (rx_data)            ck_acc_q <= ck_acc_q ^ bus.s_data;
            end
            if (rd_real) raddr_q <= rd_idx_q[log2regs-1:0];
            // Even beats park in pend_q; the odd beat releases both words as one dual write.
            if (rx_data) begin
                if (!rx_cnt_q[0]) begin
                    pend_q <= bus.s_data;
                end else begin
                    wr_vld_q <= 1'b1;
                    waddr0_q <= rx_cnt_q[log2regs-1:0] & ~ONE_A;
                    waddr1_q <= rx_cnt_q[log2regs-1:0];
                    wdat0_q  <= pend_q;
                    wdat1_q  <= bus.s_data;
                end
            end
        end
    end

`ifdef REGFILE_CTX_CHECKSUM_EN
    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
        if (!CGRA_Reset)                            ck_err <= 1'b0;
        else if (cmd_acc)                           ck_err <= 1'b0;
        else if (s_acc && (rx_cnt_q == N_REGS_C))   ck_err <= (bus.s_data != ck_acc_q);
    end
`endif
endmodule

// File: tb/tb_regfile_ctx_seq.sv
// Bench for regfile_ctx_seq: behavioural register file, randomized save/restore streams vs. expected word lists.
`timescale 1ns/1ps
module tb_regfile_ctx_seq;
    localparam int L = 3;
    localparam int W = 32;
    localparam int N = 1 << L;
`ifdef REGFILE_CTX_CHECKSUM_EN
    localparam int NB = N + 1;
`else
    localparam int NB = N;
`endif

    typedef struct packed {
        logic         we0;
        logic         we1;
        logic [L-1:0] a0;
        logic [W-1:0] d0;
        logic [L-1:0] a1;
        logic [W-1:0] d1;
    } wr_t;

    logic CGRA_Clock = 1'b0;
    logic CGRA_Reset;

    regfile_ctx_seq_if #(.log2regs(L), .size(W)) bus ();
`ifdef REGFILE_CTX_CHECKSUM_EN
    logic ck_err;
`endif

    regfile_ctx_seq #(.log2regs(L), .size(W)) dut (
        .CGRA_Clock (CGRA_Clock),
        .CGRA_Reset (CGRA_Reset),
        .bus        (bus)
`ifdef REGFILE_CTX_CHECKSUM_EN
        ,
        .ck_err     (ck_err)
`endif
    );

    always #5 CGRA_Clock = ~CGRA_Clock;

    // Register file model: registered read, two write ports, backdoor load port.
    logic [W-1:0] rf_mem [N];
    wr_t          wr_log [$];
    wr_t          wr_ent;
    logic         bd_we = 1'b0;
    logic [L-1:0] bd_addr = '0;
    logic [W-1:0] bd_dat = '0;

    always @(posedge CGRA_Clock) begin
        if (bus.rf_WE0 || bus.rf_WE1) begin
            wr_ent = {bus.rf_WE0, bus.rf_WE1, bus.rf_address_in0, bus.rf_in0, bus.rf_address_in1, bus.rf_in1};
            wr_log.push_back(wr_ent);
        end
        if (bus.rf_WE0) rf_mem[bus.rf_address_in0] <= bus.rf_in0;
        if (bus.rf_WE1) rf_mem[bus.rf_address_in1] <= bus.rf_in1;
        if (bd_we)      rf_mem[bd_addr] <= bd_dat;
        bus.rf_out0 <= rf_mem[bus.rf_address_out0];
    end

    int n_chk = 0;
    int n_fail = 0;
    logic [W-1:0] img  [N];
    logic [W-1:0] stim [NB];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] xor_words();
        logic [W-1:0] x;
        x = '0;
        for (int i = 0; i < N; i++) x ^= stim[i];
        return x;
    endfunction

    task automatic preload();
        for (int i = 0; i < N; i++) begin
            bd_we   = 1'b1;
            bd_addr = L'(i);
            bd_dat  = img[i];
            @(negedge CGRA_Clock);
        end
        bd_we = 1'b0;
    endtask

    // mode 0: m_ready always 1; mode 1: pattern 1,0,0 repeating; mode 2: random
    task automatic do_save(input int mode);
        logic [W-1:0] exp_q [$];
        logic [W-1:0] ck, held;
        int beat, cyc;
        bit stalled, early_done;
        ck = '0;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(img[i]);
            ck ^= img[i];
        end
`ifdef REGFILE_CTX_CHECKSUM_EN
        exp_q.push_back(ck);
`endif
        bus.cmd_valid = 1'b1;
        bus.cmd_save  = 1'b1;
        @(negedge CGRA_Clock);
        check_eq("save_busy", bus.busy, 1'b1);
`ifdef REGFILE_CTX_CHECKSUM_EN
        check_eq("save_ck_err_clr", ck_err, 1'b0);
`endif
        bus.cmd_save = 1'b0;
        beat = 0; cyc = 0; stalled = 0; early_done = 0; held = '0;
        while (beat < NB && cyc < 400) begin
            case (mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = (cyc % 3 == 0);
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
            if (bus.done) early_done = 1;
            if (stalled && bus.m_valid) check_eq("save_stall_hold", bus.m_data, held);
            stalled = 0;
            if (bus.m_valid && bus.m_ready) begin
                check_eq("save_data", bus.m_data, exp_q[beat]);
                check_eq("save_last", bus.m_last, (beat == NB - 1));
                beat++;
            end else if (bus.m_valid) begin
                stalled = 1;
                held    = bus.m_data;
            end
            @(negedge CGRA_Clock);
            cyc++;
        end
        bus.m_ready = 1'b0;
        check_eq("save_beats", beat, NB);
        check_eq("save_early_done", early_done, 1'b0);
        check_eq("save_done", bus.done, 1'b1);
        bus.cmd_valid = 1'b0;
        @(negedge CGRA_Clock);
        check_eq("save_idle", {bus.busy, bus.done, bus.cmd_ready, bus.m_valid}, 4'b0010);
    endtask

    task automatic do_restore(input bit gaps);
        int beat, cyc, base;
        logic exp_ck;
        exp_ck = 1'b0;
`ifdef REGFILE_CTX_CHECKSUM_EN
        exp_ck = (stim[N] != xor_words());
`endif
        base = wr_log.size();
        bus.cmd_valid = 1'b1;
        bus.cmd_save  = 1'b0;
        @(negedge CGRA_Clock);
        check_eq("restore_sready", bus.s_ready, 1'b1);
        beat = 0; cyc = 0;
        while (beat < NB && cyc < 400) begin
            bus.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_data  = bus.s_valid ? stim[beat] : W'($urandom);
            if (bus.s_valid && bus.s_ready) beat++;
            @(negedge CGRA_Clock);
            cyc++;
        end
        bus.s_valid = 1'b0;
        check_eq("restore_beats", beat, NB);
        check_eq("restore_sready_low", bus.s_ready, 1'b0);
`ifndef REGFILE_CTX_CHECKSUM_EN
        check_eq("restore_last_we", {bus.rf_WE0, bus.rf_WE1, bus.done}, 3'b110);
        @(negedge CGRA_Clock);
`endif
        check_eq("restore_done", bus.done, 1'b1);
`ifdef REGFILE_CTX_CHECKSUM_EN
        check_eq("ck_err", ck_err, exp_ck);
`endif
        bus.cmd_valid = 1'b0;
        @(negedge CGRA_Clock);
        check_eq("restore_idle", {bus.busy, bus.done, bus.cmd_ready, bus.rf_WE0}, 4'b0010);
`ifdef REGFILE_CTX_CHECKSUM_EN
        check_eq("ck_err_hold", ck_err, exp_ck);
`endif
        check_eq("restore_nwrites", wr_log.size() - base, N / 2);
        for (int k = 0; k < N / 2 && base + k < wr_log.size(); k++)
            check_eq("restore_pair", wr_log[base + k],
                     {2'b11, L'(2 * k), stim[2 * k], L'(2 * k + 1), stim[2 * k + 1]});
        for (int i = 0; i < N; i++) check_eq("restore_rf", rf_mem[i], stim[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat, cyc, base;
        logic [W-1:0] old2, old3;
        CGRA_Reset    = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_save  = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.m_ready   = 1'b0;
        #2 CGRA_Reset = 1'b0;
        repeat (3) @(negedge CGRA_Clock);
        check_eq("reset_ctrl", {bus.cmd_ready, bus.busy, bus.done, bus.m_valid, bus.m_last,
                                bus.s_ready, bus.rf_WE0, bus.rf_WE1}, 8'b1000_0000);
        check_eq("reset_addr", {bus.rf_address_in0, bus.rf_address_in1, bus.rf_address_out0}, 0);
        check_eq("reset_data", {bus.rf_in0, bus.rf_in1, bus.m_data}, 0);
        CGRA_Reset = 1'b1;
        @(negedge CGRA_Clock);
        check_eq("post_reset_idle", {bus.cmd_ready, bus.busy}, 2'b10);

        for (int i = 0; i < N; i++) img[i] = W'(32'h10 + i);
        preload();
        do_save(0);
        do_save(1);

        for (int i = 0; i < N; i++) stim[i] = W'(32'hA0 + i);
`ifdef REGFILE_CTX_CHECKSUM_EN
        stim[N] = 32'h00;
        do_restore(1'b0);
        stim[N] = 32'h01;
`endif
        do_restore(1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) img[i] = W'($urandom);
            preload();
            do_save(2);
            for (int i = 0; i < N; i++) stim[i] = W'($urandom);
`ifdef REGFILE_CTX_CHECKSUM_EN
            stim[N] = xor_words();
`endif
            do_restore(1'b1);
        end

        // Reset pulse after beat 3 is accepted: pair (2,3) must never be written.
        for (int i = 0; i < N; i++) stim[i] = W'($urandom);
        old2 = rf_mem[2];
        old3 = rf_mem[3];
        base = wr_log.size();
        bus.cmd_valid = 1'b1;
        bus.cmd_save  = 1'b0;
        @(negedge CGRA_Clock);
        beat = 0; cyc = 0;
        bus.s_valid = 1'b1;
        while (beat < 4 && cyc < 100) begin
            bus.s_data = stim[beat];
            if (bus.s_ready) beat++;
            @(negedge CGRA_Clock);
            cyc++;
        end
        check_eq("abort_beats", beat, 4);
        CGRA_Reset    = 1'b0;
        bus.s_valid   = 1'b0;
        bus.cmd_valid = 1'b0;
        #1;
        check_eq("abort_reset_ctrl", {bus.busy, bus.done, bus.rf_WE0, bus.rf_WE1, bus.s_ready,
                                      bus.m_valid, bus.cmd_ready}, 7'b000_0001);
        check_eq("abort_reset_addr", {bus.rf_address_in0, bus.rf_address_in1, bus.rf_address_out0,
                                      bus.rf_in0, bus.rf_in1}, 0);
        @(negedge CGRA_Clock);
        CGRA_Reset = 1'b1;
        @(negedge CGRA_Clock);
        check_eq("abort_idle", {bus.cmd_ready, bus.busy, bus.s_ready}, 3'b100);
        @(negedge CGRA_Clock);
        check_eq("abort_nwrites", wr_log.size() - base, 1);
        check_eq("abort_rf2", rf_mem[2], old2);
        check_eq("abort_rf3", rf_mem[3], old3);
        check_eq("abort_rf0", rf_mem[0], stim[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_ctx_seq.md
REGFILE_CTX_SEQ -- requirements
Module: regfile_ctx_seq

Interface
REQ-001 The block SHALL have parameter log2regs, default 3, giving the register-file address width; the register count is 2**log2regs, and log2regs SHALL be at least 1.
REQ-002 The block SHALL have parameter size, default 32, giving the data word width.
REQ-003 CGRA_Clock  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 CGRA_Reset  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1; cmd_ready  output  1; cmd_save  input  1  command handshake (1 = save context, 0 = restore context).
REQ-006 busy  output  1  high while a command is executing; done  output  1  one-cycle pulse when a command completes.
REQ-007 rf_WE0, rf_WE1  output  1  write enables to the register file's two write ports.
REQ-008 rf_address_in0, rf_address_in1  output  log2regs  write addresses.
REQ-009 rf_in0, rf_in1  output  size  write data.
REQ-010 rf_address_out0  output  log2regs  read address; rf_out0  input  size  registered read data, valid one cycle after its address is presented.
REQ-011 s_valid  input  1; s_ready  output  1; s_data  input  size  restore input stream.
REQ-012 m_valid  output  1; m_ready  input  1; m_data  output  size; m_last  output  1  save output stream.

Function
REQ-013 States SHALL be IDLE, SAVE, RESTORE and DONE; cmd_ready SHALL be 1 only in IDLE, and a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-014 IDLE SHALL move to SAVE or RESTORE on command acceptance, per cmd_save; busy SHALL be 1 in SAVE, RESTORE and DONE.
REQ-015 SAVE: the block SHALL read addresses 0..2**log2regs-1 in ascending order, issuing at most one read per cycle, and only when (output FIFO occupancy + reads in flight) < 2.
REQ-016 SAVE: read data SHALL enter a 2-entry output FIFO one cycle after issue; m_valid SHALL be 1 when the FIFO is non-empty, and a word is transferred when m_valid and m_ready are both 1.
REQ-017 SAVE: m_data SHALL hold stable while m_valid=1 and m_ready=0; no word SHALL be lost or duplicated under any m_ready pattern.
REQ-018 SAVE: m_last SHALL be 1 on the final beat only; SAVE SHALL move to DONE after the m_last beat transfers.
REQ-019 RESTORE: s_ready SHALL be 1 throughout RESTORE until the final word is accepted; beat j carries the word for register j.
REQ-020 RESTORE: an even-indexed beat 2k SHALL be held in a pending register and no write SHALL occur for it in that cycle.
REQ-021 RESTORE: on odd-indexed beat 2k+1, rf_WE0 and rf_WE1 SHALL assert together for one cycle, writing the pending word to address 2k (port 0) and s_data to address 2k+1 (port 1), both registered, in the cycle after acceptance.
REQ-022 RESTORE SHALL move to DONE after the last pair's write cycle.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 rf_WE0 and rf_WE1 SHALL be 0 outside RESTORE write cycles; rf_address_out0 SHALL hold its last value when no read is issued.
REQ-025 cmd_valid SHALL be ignored while busy=1.

Reset
REQ-026 Asserting CGRA_Reset (low) at any time SHALL immediately force IDLE and set outputs as follows: busy, done, m_valid, m_last, s_ready, rf_WE0 and rf_WE1 to 0; all addresses and data outputs to 0; cmd_ready to 1 once the state is IDLE; the FIFO and pending register cleared.
REQ-027 A reset during RESTORE SHALL suppress any not-yet-issued write; a reset during SAVE SHALL discard buffered words.

Configuration
REQ-028 With macro REGFILE_CTX_CHECKSUM_EN defined, SAVE SHALL append one extra beat carrying the XOR of all saved words, and m_last SHALL move to that beat.
REQ-029 With REGFILE_CTX_CHECKSUM_EN defined, RESTORE SHALL accept one extra beat and compare it to the XOR of the restored words.
REQ-030 With REGFILE_CTX_CHECKSUM_EN defined, an output ck_err (1 bit) SHALL be set on mismatch, concurrent with done, and held until the next command is accepted; the register writes are not undone.
REQ-031 Without REGFILE_CTX_CHECKSUM_EN, the block SHALL have no extra beat and no ck_err port.

Verification
REQ-032 Registers preloaded with 0x10..0x17, save with m_ready=1 -> m_data 0x10..0x17 in order, m_last on 0x17, done one cycle after the last beat.
REQ-033 Save with m_ready toggling 1,0,0,1,... -> the same 8 words with no loss or duplication, and m_data stable while stalled.
REQ-034 Restore stream 0xA0..0xA7 -> exactly four dual-write cycles: (0,0xA0)/(1,0xA1) ... (6,0xA6)/(7,0xA7).
REQ-035 CGRA_Reset pulsed low after restore beat 3 -> pair (2,3) is never written, and on release the state is IDLE with cmd_ready=1.
REQ-036 With REGFILE_CTX_CHECKSUM_EN, restore 0xA0..0xA7 plus checksum 0x00 -> ck_err=0; plus checksum 0x01 -> ck_err=1.
